// File: rtl/fpu_writeback_ctrl.sv
// ============================================================================
// Module      : fpu_writeback_ctrl
// Description : FPU writeback/commit stage. Tracks one in-flight instruction,
//               commits its result to the FP or integer register file, and
//               accumulates the IEEE exception flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_writeback_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [4:0]      issue_rd,
    input  logic            issue_dest_int,
    input  logic [XLEN-1:0] fpu_result_1,
    input  logic            fpu_complete,
    input  logic [XLEN-1:0] fpu_result_rd,
    input  logic            fpu_complete_rd,
    input  logic [4:0]      sflags,
    input  logic            iv_exception,
    input  logic            flush,
    input  logic            csr_fflags_we,
    input  logic [4:0]      csr_fflags_wdata,
    output logic            fpr_we,
    output logic [4:0]      fpr_waddr,
    output logic [XLEN-1:0] fpr_wdata,
    output logic            gpr_we,
    output logic [4:0]      gpr_waddr,
    output logic [XLEN-1:0] gpr_wdata,
    output logic [4:0]      fflags,
    output logic            iv_trap,
    output logic            busy,
    output logic            timeout_err
);

    localparam int c_CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [4:0]           r_rd;
    logic                 r_dest_int;
    logic [c_CNT_W-1:0]   r_count;
    logic [4:0]           r_sflags;
    logic                 w_match;
    logic                 w_issue_take;
    logic                 w_complete;
    logic                 w_timeout;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_issue_take = 1'b0;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        // Only the strobe belonging to the tracked destination file counts.
        w_match      = r_dest_int ? fpu_complete_rd : fpu_complete;
        case (r_state)
            S_IDLE: begin
                if (issue_valid) begin
                    w_issue_take = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else if (w_match) begin
                    w_complete   = 1'b1;
                    w_state_next = S_WB;
                end else if (r_count == c_CNT_W'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WB: begin
                if (issue_valid) begin
                    w_issue_take = 1'b1;
                    w_state_next = S_WAIT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rd        <= 5'd0;
            r_dest_int  <= 1'b0;
            r_count     <= '0;
            r_sflags    <= 5'd0;
            fpr_we      <= 1'b0;
            fpr_waddr   <= 5'd0;
            fpr_wdata   <= '0;
            gpr_we      <= 1'b0;
            gpr_waddr   <= 5'd0;
            gpr_wdata   <= '0;
            fflags      <= 5'd0;
            iv_trap     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            fpr_we      <= w_complete && !r_dest_int;
            gpr_we      <= w_complete && r_dest_int && (r_rd != 5'd0);
            iv_trap     <= w_complete && iv_exception;
            timeout_err <= w_timeout;

            if (w_issue_take) begin
                r_rd       <= issue_rd;
                r_dest_int <= issue_dest_int;
                r_count    <= '0;
            end else if (r_state == S_WAIT) begin
                r_count <= r_count + c_CNT_W'(1);
            end

            if (w_complete) begin
                r_sflags <= sflags;
            end
            if (w_complete && !r_dest_int) begin
                fpr_waddr <= r_rd;
                fpr_wdata <= fpu_result_1;
            end
            if (w_complete && r_dest_int && (r_rd != 5'd0)) begin
                gpr_waddr <= r_rd;
                gpr_wdata <= fpu_result_rd;
            end

            // Flags of the committing op merge during the write cycle, so they
            // become visible one cycle after the write enable; a CSR write in
            // that same cycle is ORed with them rather than overriding them.
            fflags <= (csr_fflags_we ? csr_fflags_wdata : fflags)
                    | ((r_state == S_WB) ? r_sflags : 5'd0);
        end
    end

    assign issue_ready = (r_state == S_IDLE) || (r_state == S_WB);
    assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fpu_writeback_ctrl.sv
// ============================================================================
// Module      : tb_fpu_writeback_ctrl
// Description : Directed and randomized bench for fpu_writeback_ctrl with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_writeback_ctrl;

    localparam int TB_TIMEOUT = 16;
    localparam int TB_XLEN    = 32;

    logic               clk = 1'b0;
    logic               rst_l;
    logic               issue_valid;
    logic               issue_ready;
    logic [4:0]         issue_rd;
    logic               issue_dest_int;
    logic [TB_XLEN-1:0] fpu_result_1;
    logic               fpu_complete;
    logic [TB_XLEN-1:0] fpu_result_rd;
    logic               fpu_complete_rd;
    logic [4:0]         sflags;
    logic               iv_exception;
    logic               flush;
    logic               csr_fflags_we;
    logic [4:0]         csr_fflags_wdata;
    logic               fpr_we;
    logic [4:0]         fpr_waddr;
    logic [TB_XLEN-1:0] fpr_wdata;
    logic               gpr_we;
    logic [4:0]         gpr_waddr;
    logic [TB_XLEN-1:0] gpr_wdata;
    logic [4:0]         fflags;
    logic               iv_trap;
    logic               busy;
    logic               timeout_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the pending instruction and what it must produce.
    bit                 m_waiting;
    bit                 m_in_wb;
    int                 m_age;
    logic [4:0]         m_rd;
    bit                 m_dest_int;
    logic [4:0]         m_sflags;
    logic               e_fpr_we;
    logic [4:0]         e_fpr_waddr;
    logic [TB_XLEN-1:0] e_fpr_wdata;
    logic               e_gpr_we;
    logic [4:0]         e_gpr_waddr;
    logic [TB_XLEN-1:0] e_gpr_wdata;
    logic [4:0]         e_fflags;
    logic               e_iv;
    logic               e_to;

    fpu_writeback_ctrl #(
        .TIMEOUT (TB_TIMEOUT),
        .XLEN    (TB_XLEN)
    ) dut (
        .clk              (clk),
        .rst_l            (rst_l),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_rd         (issue_rd),
        .issue_dest_int   (issue_dest_int),
        .fpu_result_1     (fpu_result_1),
        .fpu_complete     (fpu_complete),
        .fpu_result_rd    (fpu_result_rd),
        .fpu_complete_rd  (fpu_complete_rd),
        .sflags           (sflags),
        .iv_exception     (iv_exception),
        .flush            (flush),
        .csr_fflags_we    (csr_fflags_we),
        .csr_fflags_wdata (csr_fflags_wdata),
        .fpr_we           (fpr_we),
        .fpr_waddr        (fpr_waddr),
        .fpr_wdata        (fpr_wdata),
        .gpr_we           (gpr_we),
        .gpr_waddr        (gpr_waddr),
        .gpr_wdata        (gpr_wdata),
        .fflags           (fflags),
        .iv_trap          (iv_trap),
        .busy             (busy),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_valid      = 1'b0;
        issue_rd         = 5'd0;
        issue_dest_int   = 1'b0;
        fpu_result_1     = '0;
        fpu_complete     = 1'b0;
        fpu_result_rd    = '0;
        fpu_complete_rd  = 1'b0;
        sflags           = 5'd0;
        iv_exception     = 1'b0;
        flush            = 1'b0;
        csr_fflags_we    = 1'b0;
        csr_fflags_wdata = 5'd0;
    endtask

    task automatic model_reset();
        m_waiting = 0;
        m_in_wb   = 0;
        m_age     = 0;
        m_rd      = 5'd0;
        m_dest_int = 0;
        m_sflags  = 5'd0;
        e_fpr_we  = 1'b0; e_fpr_waddr = 5'd0; e_fpr_wdata = '0;
        e_gpr_we  = 1'b0; e_gpr_waddr = 5'd0; e_gpr_wdata = '0;
        e_fflags  = 5'd0;
        e_iv      = 1'b0;
        e_to      = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_eval();
        bit next_wb;
        next_wb  = 0;
        e_fflags = (csr_fflags_we ? csr_fflags_wdata : e_fflags) | (m_in_wb ? m_sflags : 5'd0);
        e_fpr_we = 1'b0;
        e_gpr_we = 1'b0;
        e_iv     = 1'b0;
        e_to     = 1'b0;
        if (m_waiting) begin
            if (flush) begin
                m_waiting = 0;
            end else if (m_dest_int ? fpu_complete_rd : fpu_complete) begin
                m_waiting = 0;
                next_wb   = 1;
                m_sflags  = sflags;
                e_iv      = iv_exception;
                if (!m_dest_int) begin
                    e_fpr_we = 1'b1; e_fpr_waddr = m_rd; e_fpr_wdata = fpu_result_1;
                end else if (m_rd != 5'd0) begin
                    e_gpr_we = 1'b1; e_gpr_waddr = m_rd; e_gpr_wdata = fpu_result_rd;
                end
            end else if (m_age == TB_TIMEOUT) begin
                m_waiting = 0;
                e_to      = 1'b1;
            end else begin
                m_age++;
            end
        end else if (issue_valid) begin
            m_waiting  = 1;
            m_age      = 1;
            m_rd       = issue_rd;
            m_dest_int = issue_dest_int;
        end
        m_in_wb = next_wb;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fpr_we"},      32'(fpr_we),      32'(e_fpr_we));
        chk({tag, ".fpr_waddr"},   32'(fpr_waddr),   32'(e_fpr_waddr));
        chk({tag, ".fpr_wdata"},   fpr_wdata,        e_fpr_wdata);
        chk({tag, ".gpr_we"},      32'(gpr_we),      32'(e_gpr_we));
        chk({tag, ".gpr_waddr"},   32'(gpr_waddr),   32'(e_gpr_waddr));
        chk({tag, ".gpr_wdata"},   gpr_wdata,        e_gpr_wdata);
        chk({tag, ".fflags"},      32'(fflags),      32'(e_fflags));
        chk({tag, ".iv_trap"},     32'(iv_trap),     32'(e_iv));
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(e_to));
        chk({tag, ".busy"},        32'(busy),        32'(m_waiting || m_in_wb));
        chk({tag, ".issue_ready"}, 32'(issue_ready), 32'(!m_waiting));
    endtask

    task automatic step(input string tag);
        model_eval();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rand_inputs();
        issue_valid      = ($urandom_range(1) == 0);
        issue_rd         = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
        issue_dest_int   = 1'($urandom);
        fpu_result_1     = $urandom;
        fpu_complete     = ($urandom_range(5) == 0);
        fpu_result_rd    = $urandom;
        fpu_complete_rd  = ($urandom_range(5) == 0);
        sflags           = 5'($urandom);
        iv_exception     = ($urandom_range(3) == 0);
        flush            = ($urandom_range(15) == 0);
        csr_fflags_we    = ($urandom_range(7) == 0);
        csr_fflags_wdata = 5'($urandom);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_l = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_l = 1'b1;
        #1 check_all("reset");

        // FPR path
        issue_valid = 1'b1; issue_rd = 5'd5; issue_dest_int = 1'b0;
        step("fpr_issue");
        idle_inputs();
        step("fpr_wait1");
        step("fpr_wait2");
        fpu_complete = 1'b1; fpu_result_1 = 32'h3F80_0000; sflags = 5'h01;
        step("fpr_done");
        chk("fpr_we_pulse", 32'(fpr_we), 32'd1);
        chk("fpr_waddr_5", 32'(fpr_waddr), 32'd5);
        chk("fpr_wdata_one", fpr_wdata, 32'h3F80_0000);
        idle_inputs();
        step("fpr_after");
        chk("fpr_busy_low", 32'(busy), 32'd0);
        chk("fpr_fflags", 32'(fflags), 32'h01);

        // GPR path to x0, fflags cleared by CSR at issue
        issue_valid = 1'b1; issue_rd = 5'd0; issue_dest_int = 1'b1;
        csr_fflags_we = 1'b1; csr_fflags_wdata = 5'h00;
        step("x0_issue");
        idle_inputs();
        fpu_complete_rd = 1'b1; fpu_result_rd = 32'h1234_5678; sflags = 5'h10;
        step("x0_done");
        chk("x0_gpr_we_low", 32'(gpr_we), 32'd0);
        chk("x0_iv_low", 32'(iv_trap), 32'd0);
        idle_inputs();
        step("x0_after");
        chk("x0_fflags", 32'(fflags), 32'h10);

        // Wrong strobe until timeout
        issue_valid = 1'b1; issue_rd = 5'd7; issue_dest_int = 1'b0;
        step("to_issue");
        idle_inputs();
        fpu_complete_rd = 1'b1; fpu_result_rd = 32'hDEAD_BEEF; sflags = 5'h1F;
        for (int i = 0; i < TB_TIMEOUT - 1; i++) step("to_wait");
        chk("to_still_busy", 32'(busy), 32'd1);
        step("to_last");
        chk("to_pulse", 32'(timeout_err), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        idle_inputs();
        step("to_after");
        chk("to_pulse_once", 32'(timeout_err), 32'd0);
        chk("to_fflags_kept", 32'(fflags), 32'h10);

        // Back-to-back issue colliding with a CSR write in the write cycle
        issue_valid = 1'b1; issue_rd = 5'd3; issue_dest_int = 1'b0;
        step("b2b_issue");
        idle_inputs();
        fpu_complete = 1'b1; fpu_result_1 = 32'hCAFE_0001; sflags = 5'h02;
        step("b2b_done");
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd9; issue_dest_int = 1'b1;
        csr_fflags_we = 1'b1; csr_fflags_wdata = 5'h04;
        step("b2b_wb");
        chk("b2b_fflags_or", 32'(fflags), 32'h06);
        chk("b2b_no_idle", 32'(busy), 32'd1);
        idle_inputs();
        fpu_complete_rd = 1'b1; fpu_result_rd = 32'h0000_0099;
        step("b2b_done2");
        chk("b2b_gpr_we", 32'(gpr_we), 32'd1);
        chk("b2b_gpr_waddr", 32'(gpr_waddr), 32'd9);
        idle_inputs();
        step("b2b_after");

        // Flush in WAIT, then a late strobe
        issue_valid = 1'b1; issue_rd = 5'd4; issue_dest_int = 1'b0;
        step("fl_issue");
        idle_inputs();
        flush = 1'b1;
        step("fl_flush");
        idle_inputs();
        fpu_complete = 1'b1; fpu_result_1 = 32'h1111_2222;
        step("fl_late");
        chk("fl_no_write", 32'(fpr_we), 32'd0);
        idle_inputs();

        // Invalid exception raises iv_trap alongside the write
        issue_valid = 1'b1; issue_rd = 5'd4; issue_dest_int = 1'b0;
        step("iv_issue");
        idle_inputs();
        fpu_complete = 1'b1; fpu_result_1 = 32'h7FC0_0000; iv_exception = 1'b1; sflags = 5'h10;
        step("iv_done");
        chk("iv_trap_pulse", 32'(iv_trap), 32'd1);
        chk("iv_with_we", 32'(fpr_we), 32'd1);
        idle_inputs();
        step("iv_after");
        chk("iv_trap_clear", 32'(iv_trap), 32'd0);

        // Asynchronous reset while waiting
        issue_valid = 1'b1; issue_rd = 5'd6; issue_dest_int = 1'b0;
        step("ar_issue");
        idle_inputs();
        #2 rst_l = 1'b0;
        #1;
        model_reset();
        check_all("ar_async");
        #2 rst_l = 1'b1;
        fpu_complete = 1'b1; fpu_result_1 = 32'h5555_AAAA;
        step("ar_late");
        chk("ar_no_write", 32'(fpr_we), 32'd0);
        idle_inputs();
        step("ar_after");

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
